// File: rtl/problem3_core_pkg.sv
// Shared constants and types for the problem3 truncating multiplier.
package problem3_core_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef logic [DEFAULT_WIDTH-1:0] product_t;

endpackage : problem3_core_pkg

// File: rtl/problem3_pp_row.sv
// One partial-product row: gates the multiplicand by one multiplier bit,
// shifts by the row index and accumulates into the running sum, modulo 2^WIDTH.
module problem3_pp_row
    import problem3_core_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned ROW   = 0
) (
    input  logic [WIDTH-1:0] mcand_i,
    input  logic             mbit_i,
    input  logic [WIDTH-1:0] psum_i,
    output logic [WIDTH-1:0] psum_o
);

    logic [WIDTH-1:0] pp_c;

    // Shifting within WIDTH bits drops the high product bits of this row.
    assign pp_c   = mbit_i ? (mcand_i << ROW) : '0;
    assign psum_o = psum_i + pp_c;

endmodule : problem3_pp_row

// File: rtl/problem3_core.sv
// Registered truncating unsigned multiplier built from a chain of
// shift-and-add partial-product rows; one-cycle latency, no handshake.
module problem3_core
    import problem3_core_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_p0,
    input  logic [WIDTH-1:0] i_p1,
    output logic [WIDTH-1:0] o_p
);

    logic [WIDTH-1:0] p_d;
    logic [WIDTH-1:0] p_q;

    // Each row owns its own sum net so the chain has no self-referencing vector.
    for (genvar k = 0; k < WIDTH; k++) begin : g_row
        logic [WIDTH-1:0] sum_in;
        logic [WIDTH-1:0] sum;

        if (k == 0) begin : g_first
            assign sum_in = '0;
        end else begin : g_next
            assign sum_in = g_row[k-1].sum;
        end

        problem3_pp_row #(
            .WIDTH (WIDTH),
            .ROW   (k)
        ) u_row (
            .mcand_i (i_p0),
            .mbit_i  (i_p1[k]),
            .psum_i  (sum_in),
            .psum_o  (sum)
        );
    end

    assign p_d = g_row[WIDTH-1].sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign o_p = p_q;

endmodule : problem3_core

// File: tb/tb_problem3_core.sv
// Self-checking bench for problem3_core: directed vector table, reset
// corner sequences and randomized back-to-back traffic against a product model.
module tb_problem3_core;
    import problem3_core_pkg::*;

    localparam int unsigned W = DEFAULT_WIDTH;

    typedef struct {
        string    name;
        product_t a;
        product_t b;
        product_t exp;
    } vec_t;

    logic     clk;
    logic     rst_n;
    product_t a;
    product_t b;
    product_t p;

    int n_checks;
    int n_fail;

    vec_t vecs[10];

    problem3_core #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .i_p0  (a),
        .i_p1  (b),
        .o_p   (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input product_t act, input product_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Full-width product, then keep the low W bits.
    function automatic product_t ref_mul(input product_t x, input product_t y);
        logic [2*W-1:0] full;
        full = (2*W)'(x) * (2*W)'(y);
        return W'(full);
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{"0f0f*0f0f",   16'h0f0f, 16'h0f0f, 16'hc2e1};
        vecs[1] = '{"3366*6633",   16'h3366, 16'h6633, 16'he152};
        vecs[2] = '{"6633*3366",   16'h6633, 16'h3366, 16'he152};
        vecs[3] = '{"1234*5678",   16'h1234, 16'h5678, 16'h0060};
        vecs[4] = '{"ffff*ffff",   16'hffff, 16'hffff, 16'h0001};
        vecs[5] = '{"0000*abcd",   16'h0000, 16'habcd, 16'h0000};
        vecs[6] = '{"0001*abcd",   16'h0001, 16'habcd, 16'habcd};
        vecs[7] = '{"abcd*0001",   16'habcd, 16'h0001, 16'habcd};
        vecs[8] = '{"8000*0002",   16'h8000, 16'h0002, 16'h0000};
        vecs[9] = '{"abcd*0000",   16'habcd, 16'h0000, 16'h0000};

        // Reset held from time zero, then released between edges.
        rst_n = 1'b0;
        a     = 16'h0f0f;
        b     = 16'h0f0f;
        repeat (2) @(posedge clk);
        #1 check("reset_hold", p, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("after_release", p, 16'h0000);
        @(posedge clk);
        #1 check("first_capture", p, 16'hc2e1);

        // Mid-cycle reset clears the output without a clock edge.
        #2 rst_n = 1'b0;
        #1 check("async_clear", p, 16'h0000);
        @(posedge clk);
        #1 check("clear_held", p, 16'h0000);
        rst_n = 1'b1;
        #1 check("no_recovery", p, 16'h0000);

        // Directed table, one pair per cycle; output must not move before the edge.
        for (int i = 0; i < 10; i++) begin
            product_t prev;
            prev = p;
            a = vecs[i].a;
            b = vecs[i].b;
            #1 check({vecs[i].name, "_pre_edge"}, p, prev);
            @(posedge clk);
            #1 check(vecs[i].name, p, vecs[i].exp);
        end

        // Randomized back-to-back traffic with a reset pulse mid-stream.
        for (int i = 0; i < 1000; i++) begin
            a = W'($urandom());
            b = W'($urandom());
            if (i % 97 == 5)  a = '1;
            if (i % 89 == 11) b = W'(1);
            if (i == 500) begin
                #2 rst_n = 1'b0;
                #1 check("rand_async_clear", p, 16'h0000);
                @(posedge clk);
                #1 check("rand_clear_held", p, 16'h0000);
                rst_n = 1'b1;
                #1 check("rand_after_release", p, 16'h0000);
            end
            @(posedge clk);
            #1 check("random", p, ref_mul(a, b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_problem3_core
